if_stage_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage ARM pipeline.
- Holds the PC and drives the instruction memory word address. Registers the returned instruction and PC+4 into the IF/ID pipeline register.
- Honours freeze from the hazard unit and redirect/flush from the EX-stage branch resolution.
- Sits between the hazard/branch logic and the ID stage; the instruction memory is combinational and returns data in the same cycle.

---
 rtl/arm_pipe_pkg.sv | 15 +
 rtl/if_stage_unit_pc_reg.sv | 22 ++
 rtl/if_stage_unit.sv | 80 ++++++++
 tb/tb_if_stage_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline front end.
package arm_pipe_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_unit_pc_reg.sv
// Program-counter register: async active-low reset, load-enabled update.
module pc_reg
  import arm_pipe_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC, imem addressing and the IF/ID pipeline register.
// Optional fetch/stall counters are built when IF_PERF_CNT_EN is defined.
module if_stage_unit
  import arm_pipe_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = arm_pipe_pkg::RESET_PC,
  parameter logic [WORD_W-1:0] NOP_INST = arm_pipe_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_adr,
  output logic [WORD_W-1:0] imem_adr,
  input  logic [WORD_W-1:0] imem_inst,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] id_pc,
  output logic [WORD_W-1:0] id_inst,
  output logic              id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] fetch_cnt,
  output logic [WORD_W-1:0] stall_cnt
`endif
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_next;
  logic              pc_load;
  if_id_t            if_id;

  // A redirect always loads; otherwise the PC advances unless frozen.
  assign pc_load = branch_taken | ~freeze;
  assign pc_next = branch_taken ? (branch_adr & ~WORD_W'(3)) : pc_plus4;

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pc_next),
    .q   (pc)
  );

  assign pc_plus4 = pc + WORD_W'(4);
  assign imem_adr = {2'b00, pc[WORD_W-1:2]};

  // IF/ID register: flush beats freeze, freeze beats load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_id <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else if (branch_taken) begin
      if_id <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
    end else if (!freeze) begin
      if_id <= '{pc: pc_plus4, inst: imem_inst, valid: 1'b1};
    end
  end

  assign id_pc    = if_id.pc;
  assign id_inst  = if_id.inst;
  assign id_valid = if_id.valid;

`ifdef IF_PERF_CNT_EN
  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (!branch_taken) begin
      if (freeze) begin
        stall_cnt <= stall_cnt + WORD_W'(1);
      end else begin
        fetch_cnt <= fetch_cnt + WORD_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Self-checking bench for if_stage_unit against a cycle-level behavioural model.
module tb_if_stage_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_adr;
  logic [31:0] imem_adr;
  logic [31:0] imem_inst;
  logic [31:0] pc_plus4;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Memory model: instruction = word address XOR a per-test salt.
  logic [31:0] mem_salt = 32'h0;
  assign imem_inst = imem_adr ^ mem_salt;

  // Reference model state
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_fetch, m_stall;
  logic        m_valid;

  if_stage_unit dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_adr  (branch_adr),
    .imem_adr    (imem_adr),
    .imem_inst   (imem_inst),
    .pc_plus4    (pc_plus4),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_valid = 1'b0;
    m_fetch = 32'h0; m_stall = 32'h0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input logic fr, input logic br, input logic [31:0] adr);
    if (br) begin
      m_pc = {adr[31:2], 2'b00};
      m_id_inst = 32'h0; m_id_pc = 32'h0; m_valid = 1'b0;
    end else if (fr) begin
      m_stall = m_stall + 1;
    end else begin
      m_id_inst = (m_pc / 4) ^ mem_salt;
      m_id_pc   = m_pc + 32'd4;
      m_valid   = 1'b1;
      m_pc      = m_pc + 32'd4;
      m_fetch   = m_fetch + 1;
    end
  endtask

  // Apply inputs, take one rising edge, return at the following falling edge.
  task automatic cycle(input logic fr, input logic br, input logic [31:0] adr);
    freeze = fr; branch_taken = br; branch_adr = adr;
    @(posedge clk);
    model_edge(fr, br, adr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    freeze = 1'b0; branch_taken = 1'b0; branch_adr = 32'h0; mem_salt = 32'h0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_adr !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL reset_pc: imem_adr=%h pc_plus4=%h, want 0/4", imem_adr, pc_plus4);
    end
    checks++;
    if (id_pc !== 32'h0 || id_inst !== 32'h0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ifid: id_pc=%h id_inst=%h id_valid=%b, want 0/0/0", id_pc, id_inst, id_valid);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: fetch=%0d stall=%0d, want 0/0", fetch_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_fetch();
    do_reset();
    mem_salt = 32'h0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_adr !== 32'd3 || pc_plus4 !== 32'd16) begin
      errors++; $display("FAIL fetch_pc: imem_adr=%0d pc_plus4=%0d, want 3/16", imem_adr, pc_plus4);
    end
    checks++;
    if (id_inst !== 32'd2 || id_pc !== 32'd12 || id_valid !== 1'b1) begin
      errors++; $display("FAIL fetch_ifid: id_inst=%0d id_pc=%0d id_valid=%b, want 2/12/1", id_inst, id_pc, id_valid);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] held_inst, held_pc;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    held_inst = 32'd1; held_pc = 32'd8;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (imem_adr !== 32'd2 || id_inst !== held_inst || id_pc !== held_pc || id_valid !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: imem_adr=%0d id_inst=%0d id_pc=%0d, want 2/%0d/%0d", i, imem_adr, id_inst, id_pc, held_inst, held_pc);
      end
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd3 || fetch_cnt !== 32'd2) begin
      errors++; $display("FAIL freeze_cnt: stall=%0d fetch=%0d, want 3/2", stall_cnt, fetch_cnt);
    end
`endif
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_adr !== 32'd3 || id_inst !== 32'd2 || id_pc !== 32'd12) begin
      errors++; $display("FAIL freeze_release: imem_adr=%0d id_inst=%0d id_pc=%0d, want 3/2/12", imem_adr, id_inst, id_pc);
    end
  endtask

  task automatic test_branch_freeze();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_1003);
    checks++;
    if (imem_adr !== 32'h400 || pc_plus4 !== 32'h1004 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL branch_flush: imem_adr=%h id_valid=%b id_inst=%h id_pc=%h, want 400/0/0/0", imem_adr, id_valid, id_inst, id_pc);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (id_inst !== 32'h400 || id_pc !== 32'h1004 || id_valid !== 1'b1) begin
      errors++; $display("FAIL branch_target: id_inst=%h id_pc=%h id_valid=%b, want 400/1004/1", id_inst, id_pc, id_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
    checks++;
    if (imem_adr !== 32'h3FFF_FFFF || pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pre: imem_adr=%h pc_plus4=%h, want 3fffffff/0", imem_adr, pc_plus4);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_adr !== 32'h0 || id_pc !== 32'h0 || id_inst !== 32'h3FFF_FFFF || id_valid !== 1'b1) begin
      errors++; $display("FAIL wrap: imem_adr=%h id_pc=%h id_inst=%h, want 0/0/3fffffff", imem_adr, id_pc, id_inst);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_adr !== 32'd10 || id_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset: imem_adr=%0d id_valid=%b, want 10/1", imem_adr, id_valid);
    end
    // Pending redirect while reset falls between edges
    branch_taken = 1'b1; branch_adr = 32'h0000_5000;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (imem_adr !== 32'h0 || id_pc !== 32'h0 || id_inst !== 32'h0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: imem_adr=%h id_pc=%h id_inst=%h id_valid=%b, want 0/0/0/0", imem_adr, id_pc, id_inst, id_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem_adr !== 32'h0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold: imem_adr=%h id_valid=%b, want 0/0", imem_adr, id_valid);
    end
    branch_taken = 1'b0;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_adr !== 32'd1 || id_inst !== 32'd0 || id_pc !== 32'd4 || id_valid !== 1'b1) begin
      errors++; $display("FAIL restart: imem_adr=%0d id_inst=%0d id_pc=%0d, want 1/0/4", imem_adr, id_inst, id_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0100);
    cycle(1'b0, 1'b1, 32'h0000_0200);
    checks++;
    if (imem_adr !== 32'h80 || id_valid !== 1'b0 || id_inst !== 32'h0) begin
      errors++; $display("FAIL b2b_flush: imem_adr=%h id_valid=%b id_inst=%h, want 80/0/0", imem_adr, id_valid, id_inst);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (id_inst !== 32'h80 || id_pc !== 32'h204 || id_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_target: id_inst=%h id_pc=%h id_valid=%b, want 80/204/1", id_inst, id_pc, id_valid);
    end
  endtask

  task automatic test_random();
    logic        fr, br;
    logic [31:0] adr;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      mem_salt = $urandom;
      fr  = ($urandom_range(0, 9) < 3);
      br  = ($urandom_range(0, 9) < 2);
      adr = $urandom;
      cycle(fr, br, adr);
      checks++;
      if (imem_adr !== (m_pc / 4) || pc_plus4 !== m_pc + 32'd4 || id_pc !== m_id_pc ||
          id_inst !== m_id_inst || id_valid !== m_valid) begin
        errors++;
        $display("FAIL random[%0d]: imem_adr=%h id_pc=%h id_inst=%h v=%b, want %h/%h/%h/%b",
                 i, imem_adr, id_pc, id_inst, id_valid, m_pc / 4, m_id_pc, m_id_inst, m_valid);
      end
`ifdef IF_PERF_CNT_EN
      checks++;
      if (fetch_cnt !== m_fetch || stall_cnt !== m_stall) begin
        errors++; $display("FAIL random_cnt[%0d]: fetch=%0d stall=%0d, want %0d/%0d", i, fetch_cnt, stall_cnt, m_fetch, m_stall);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_adr = 32'h0;
    model_reset();
    test_reset();
    test_fetch();
    test_freeze();
    test_branch_freeze();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
